pc_unit: RTL
============

Name: pc_unit

Overview:
- Program-counter register plus return-address stack for the multi-cycle RISC core.
- Consumes the 2-bit pc_src selection produced by pc_control and updates the PC when the main control FSM asserts pc_write in the PC-update cycle.
- Holds CALL return addresses in a LIFO stack and supplies them on RET.
- Drives the instruction-fetch address.

Parameters:
- ADDR_W, 32, PC and address width in bits; the PC is word-addressed.
- OFF_W, 16, width of the signed jump/branch offset input.
- STACK_DEPTH, 8, number of return-address stack entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pc_write  input  1  PC-update strobe from the main control FSM; nothing changes when it is 0.
- pc_src  input  2  next-PC select from pc_control: 00 = PC+1, 01 = jump, 10 = branch taken, 11 = return.
- offset  input  OFF_W  signed word offset for jump/branch; sign-extended to ADDR_W.
- push_ret  input  1  CALL indication; push PC+1 on this update.
- pop_ret  input  1  RET indication; pop on this update (pc_src is 11 in the same cycle).
- pc  output  ADDR_W  current program counter.
- stack_count  output  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- stack_empty  output  1  stack_count == 0.
- stack_full  output  1  stack_count == STACK_DEPTH.
- ovf_err  output  1  sticky flag: a push was attempted while the stack was full.
- unf_err  output  1  sticky flag: a pop or return was attempted while the stack was empty.

Behaviour:
- Reset (reset_n = 0, takes effect immediately, independent of clk):
  - pc = 0, stack_count = 0, ovf_err = 0, unf_err = 0.
  - Stack contents are don't-care.
  - A reset during an update aborts it; nothing from the aborted update is kept.
- Hold: with pc_write = 0, PC, stack, count and flags hold, regardless of pc_src, push_ret and pop_ret.
- Next-PC calculation (on rising edge with pc_write = 1); all arithmetic is modulo 2^ADDR_W, wrap-around is allowed and not flagged:
  - 00: pc <= pc + 1.
  - 01: pc <= pc + sext(offset).
  - 10: pc <= pc + sext(offset).
  - 11: pc <= stack[top] if the stack is non-empty. If empty, pc holds and unf_err is set.
- Push (pc_write = 1 and push_ret = 1):
  - The value pushed is the pre-update pc + 1.
  - Not full: write the value to stack[count] and increment count.
  - Full: the push is dropped, count is unchanged, ovf_err is set, and the PC update still occurs.
- Pop (pc_write = 1 and pop_ret = 1):
  - Not empty: count decrements. The PC reads the top entry before the decrement, in the same edge.
  - Empty: count stays 0 and unf_err is set.
  - pop_ret with pc_src != 11 still pops; the value is discarded.
  - pc_src = 11 without pop_ret reads the top entry without popping.
- Simultaneous push_ret and pop_ret: the pop is evaluated first, then the push, in one edge.
  - Net count is unchanged; the top entry is replaced by the new pre-update pc + 1.
  - When the stack is empty, unf_err is set and the push then proceeds, leaving count = 1.
- Latency:
  - pc reflects the update one edge after pc_write.
  - Status outputs (stack_count, stack_empty, stack_full, ovf_err, unf_err) are registered or derived from registered count, with no combinational path from the inputs.
- Sticky flags: ovf_err and unf_err clear only on reset.

Test Plan:
- Reset/hold: reset_n = 0 with pc previously 0x40 -> pc = 0 immediately. Release reset and keep pc_write = 0 for 5 cycles with pc_src = 01 -> pc stays 0.
- Sequential/jump/branch: three updates with pc_src = 00 -> pc = 3. Then pc_src = 01, offset = 0x0010 -> pc = 0x13. Then pc_src = 10, offset = 0xFFFE (-2) -> pc = 0x11.
- Call/return: pc = 0x20, pc_src = 01, offset = 0x30, push_ret = 1 -> pc = 0x50, stack_count = 1. Next pc_src = 11, pop_ret = 1 -> pc = 0x21, stack_empty = 1.
- Overflow: 9 CALLs with STACK_DEPTH = 8 -> after the 8th, stack_full = 1. The 9th leaves count = 8, sets ovf_err = 1, and pc still jumps. 8 RETs then return the addresses in reverse order.
- Underflow: empty stack, pc = 0x7, pc_src = 11, pop_ret = 1 -> pc stays 0x7, unf_err = 1, count = 0. unf_err stays 1 through later normal updates until reset.
- Simultaneous push/pop and wrap: count = 2, pc = 0x100, push_ret = pop_ret = 1, pc_src = 11 -> pc = old top, count = 2, top = 0x101. Separately, pc = 0xFFFFFFFF with pc_src = 00 -> pc = 0x00000000 and no flags set.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter plus return-address stack for the multi-cycle core.
// The PC changes only on edges where pc_write is high. pc_src selects the
// next PC: sequential, jump, branch or return. CALL/RET push and pop the
// LIFO stack. Within one update the pop is applied before the push.
module pc_unit #(
    parameter int ADDR_W      = 32,
    parameter int OFF_W       = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           pc_write,
    input  logic [1:0]                     pc_src,
    input  logic [OFF_W-1:0]               offset,
    input  logic                           push_ret,
    input  logic                           pop_ret,
    output logic [ADDR_W-1:0]              pc,
    output logic [$clog2(STACK_DEPTH):0]   stack_count,
    output logic                           stack_empty,
    output logic                           stack_full,
    output logic                           ovf_err,
    output logic                           unf_err
);
    localparam int IW = $clog2(STACK_DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [ADDR_W-1:0] pc_q, pc_next, pc_inc, off_sext, top_val;
    logic [CW-1:0]     count_q, count_m1, cnt_mid, cnt_next;
    logic              ovf_q, unf_q, empty, do_pop, do_push, push_ovf, ret_unf;

    // Next-state terms. The pop is applied first to give an intermediate
    // count, and the push is then judged against that count. As a result a
    // push and a pop on a full stack replace the top entry and are not
    // counted as an overflow.
    always_comb begin
        empty    = (count_q == '0);
        count_m1 = count_q - CW'(1);
        top_val  = stack_mem[count_m1[IW-1:0]];
        pc_inc   = pc_q + ADDR_W'(1);
        off_sext = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
        do_pop   = pop_ret && !empty;
        ret_unf  = (pop_ret || (pc_src == 2'b11)) && empty;
        cnt_mid  = do_pop ? count_m1 : count_q;
        do_push  = push_ret && (cnt_mid != DEPTH_C);
        push_ovf = push_ret && (cnt_mid == DEPTH_C);
        cnt_next = do_push ? cnt_mid + CW'(1) : cnt_mid;
        pc_next  = pc_q;
        case (pc_src)
            2'b00:   pc_next = pc_inc;
            2'b01,
            2'b10:   pc_next = pc_q + off_sext;
            default: pc_next = empty ? pc_q : top_val;
        endcase
    end

    // PC, stack count and the sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (pc_write) begin
            pc_q    <= pc_next;
            count_q <= cnt_next;
            if (push_ovf) ovf_q <= 1'b1;
            if (ret_unf)  unf_q <= 1'b1;
        end
    end

    // Stack storage. It has no reset because the count marks which entries
    // are valid.
    always_ff @(posedge clk) begin
        if (reset_n && pc_write && do_push)
            stack_mem[cnt_mid[IW-1:0]] <= pc_inc;
    end

    assign pc          = pc_q;
    assign stack_count = count_q;
    assign stack_empty = empty;
    assign stack_full  = (count_q == DEPTH_C);
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;
endmodule
